counter_sched: RTL and testbench
================================

Name: counter_sched

Overview:
- Round-robin scheduler that shares the team's dual counter block (`code`: Slt/En inputs; channel 1 advances once per 4 enables) between two requesters.
- Each requester asks for a burst of N increment pulses on a chosen channel.
- The scheduler grants one requester at a time, drives Slt/En for exactly N cycles, then signals completion.
- Sits directly in front of the counter and owns its Slt/En inputs exclusively.

Parameters:
- LEN_W, 4: width of burst-length fields. Max burst is 2^LEN_W-1 pulses.

Ports:
- Clk  input  1  clock
- Reset  input  1  synchronous, active-high reset
- Req0  input  1  requester 0 request; hold until Done0
- Sel0  input  1  requester 0 channel select (0 = counter0, 1 = counter1)
- Len0  input  LEN_W  requester 0 burst length
- Req1  input  1  requester 1 request
- Sel1  input  1  requester 1 channel select
- Len1  input  LEN_W  requester 1 burst length
- Gnt0  output  1  requester 0 owns the counter (RUN state)
- Gnt1  output  1  requester 1 owns the counter
- Done0  output  1  one-cycle completion pulse to requester 0
- Done1  output  1  one-cycle completion pulse to requester 1
- Slt  output  1  to counter Slt
- En  output  1  to counter En
- Busy  output  1  state != IDLE
- Owner  output  1  index of current/last-served requester

Behaviour:
- Interface: reset is Reset, synchronous, active-high; clock is Clk. All state updates on posedge Clk only.
- Reset values: state=IDLE, remaining=0, Slt=0, Owner=0, last=1 (requester 0 wins first tie). Gnt0/Gnt1/Done0/Done1/En/Busy all 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE, winner selection:
  - Only one Req high: that requester wins.
  - Both high: winner = !last.
  - Winner's Sel and Len are latched into Slt and remaining; Owner <= winner.
- IDLE, next state:
  - Latched Len != 0: next state RUN.
  - Latched Len == 0: next state DONE directly. No Gnt, no En.
- IDLE with no Req: stay in IDLE.
- RUN:
  - En=1 and Gnt[Owner]=1 every cycle; Slt holds the latched value.
  - remaining decrements by 1 each cycle.
  - When remaining==1, next state is DONE. Exactly Len En pulses are issued, in consecutive cycles.
- DONE:
  - Done[Owner]=1 for exactly one cycle; En=0, Gnt=0.
  - last <= Owner; next state IDLE.
- Latency: Req sampled at edge t gives Gnt and first En visible in cycle t+1. Done appears in cycle t+1+Len. Next grant is no earlier than cycle t+2+Len (one IDLE cycle between bursts).
- Req, Sel and Len are sampled only in IDLE. Changes or withdrawal during RUN/DONE are ignored; the burst always completes.
- A requester still holding Req in its DONE cycle is treated as a new request in the following IDLE.
- Reset mid-burst: at the edge with Reset=1 the FSM goes to IDLE. En/Gnt are 0 from the next cycle, and no Done is issued for the aborted burst.
- Gnt0, Gnt1, Done0, Done1 are mutually exclusive; En==(Gnt0|Gnt1).

Optional Feature:
- Macro: SCHED_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 0 always wins a tie; last is unused, and requester 1 can starve.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset, then Req0=1, Sel0=0, Len0=3 at edge 1:
  - Gnt0 and En high in cycles 2-4 with Slt=0.
  - Done0 in cycle 5.
  - Counter Output0 goes 0->3, Output1 stays 0.
- Req1=1, Sel1=1, Len1=8 alone:
  - 8 consecutive En pulses with Slt=1, then Done1.
  - Counter Output1 +2; Output0 unchanged.
- Req0 and Req1 both held continuously, Len0=Len1=2:
  - Grants alternate 0,1,0,1 (first grant to 0 after reset).
  - Each burst is 2 En cycles followed by Done, then one IDLE cycle.
  - With SCHED_FIXED_PRIO_EN defined, the same stimulus gives Gnt0 only.
- Req0 with Len0=0:
  - Done0 pulses one cycle after the request edge.
  - Gnt0 and En never assert; counters unchanged.
- Req0, Len0=15: assert Reset in the 5th RUN cycle.
  - En=0, Gnt0=0, Busy=0 from the next cycle; Done0 never pulses.
  - Output0 counts only the En pulses issued before reset.
- Req0 Len0=4: drop Req0 and change Sel0 in the 2nd RUN cycle.
  - Still 4 En pulses with the original Slt, then Done0.

Source files
------------

// File: rtl/counter_sched.sv
// Round-robin burst scheduler in front of the dual counter: grants one requester at a time and drives Slt/En for Len cycles.
// Define SCHED_FIXED_PRIO_EN to make requester 0 always win a tie (requester 1 may starve).
module counter_sched #(
  parameter int LEN_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0,
  input  logic             Sel0,
  input  logic [LEN_W-1:0] Len0,
  input  logic             Req1,
  input  logic             Sel1,
  input  logic [LEN_W-1:0] Len1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Done0,
  output logic             Done1,
  output logic             Slt,
  output logic             En,
  output logic             Busy,
  output logic             Owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_remaining, w_remaining_nxt;
  logic             r_slt, w_slt_nxt;
  logic             r_owner, w_owner_nxt;
  logic             w_winner;
  logic             w_win_sel;
  logic [LEN_W-1:0] w_win_len;

`ifdef SCHED_FIXED_PRIO_EN
  assign w_winner = ~Req0;
`else
  logic r_last;

  // r_last resets to 1 so requester 0 wins the first tie.
  assign w_winner = (Req0 & Req1) ? ~r_last : Req1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_last <= 1'b1;
    end else if (r_state == S_DONE) begin
      r_last <= r_owner;
    end
  end
`endif

  assign w_win_sel = w_winner ? Sel1 : Sel0;
  assign w_win_len = w_winner ? Len1 : Len0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_slt       <= 1'b0;
      r_owner     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_slt       <= w_slt_nxt;
      r_owner     <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_slt_nxt       = r_slt;
    w_owner_nxt     = r_owner;
    case (r_state)
      S_IDLE: begin
        if (Req0 | Req1) begin
          w_slt_nxt       = w_win_sel;
          w_remaining_nxt = w_win_len;
          w_owner_nxt     = w_winner;
          // A zero-length burst skips RUN and completes immediately.
          w_state_nxt     = (w_win_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        w_remaining_nxt = r_remaining - LEN_W'(1);
        if (r_remaining == LEN_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign En    = (r_state == S_RUN);
  assign Gnt0  = En & ~r_owner;
  assign Gnt1  = En & r_owner;
  assign Done0 = (r_state == S_DONE) & ~r_owner;
  assign Done1 = (r_state == S_DONE) & r_owner;
  assign Busy  = (r_state != S_IDLE);
  assign Slt   = r_slt;
  assign Owner = r_owner;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios with literal expectations, then random traffic against a burst-queue model.
module tb_counter_sched;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Req0 = 1'b0, Sel0 = 1'b0, Req1 = 1'b0, Sel1 = 1'b0;
  logic [3:0] Len0 = '0, Len1 = '0;
  logic       Gnt0, Gnt1, Done0, Done1, Slt, En, Busy, Owner;

  counter_sched dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Sel0(Sel0), .Len0(Len0),
    .Req1(Req1), .Sel1(Sel1), .Len1(Len1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .Slt(Slt), .En(En), .Busy(Busy), .Owner(Owner)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (period %0d)", name, act, exp, cyc);
    end
  endfunction

  // Model: each accepted request becomes Len "run" entries followed by one "done" entry.
  bit m_q[$];
  bit m_slt = 0, m_owner = 0, m_last = 1, m_valid = 0;

  always @(posedge Clk) begin
    int  len;
    bit  win;
    cyc++;
    if (Reset) begin
      m_q.delete();
      m_slt = 0; m_owner = 0; m_last = 1; m_valid = 1;
    end else if (m_valid) begin
      if (m_q.size() == 0) begin
        if (Req0 || Req1) begin
`ifdef SCHED_FIXED_PRIO_EN
          win = Req0 ? 1'b0 : 1'b1;
`else
          win = (Req0 && Req1) ? !m_last : Req1;
`endif
          m_owner = win;
          m_slt   = win ? Sel1 : Sel0;
          len     = win ? int'(Len1) : int'(Len0);
          for (int i = 0; i < len; i++) m_q.push_back(1'b0);
          m_q.push_back(1'b1);
        end
      end else begin
        if (m_q[0]) m_last = m_owner;
        void'(m_q.pop_front());
      end
    end
  end

  // Trackers used by the directed scenarios.
  int en_cnt0, en_cnt1, done0_cnt, done1_cnt, done0_cyc, done1_cyc, first_en;
  int gnt_seq[$];
  int gnt_start[$];
  bit prev_gnt = 0;

  task automatic clear_trk();
    en_cnt0 = 0; en_cnt1 = 0; done0_cnt = 0; done1_cnt = 0;
    done0_cyc = -1; done1_cyc = -1; first_en = -1;
    gnt_seq.delete(); gnt_start.delete();
  endtask

  always @(negedge Clk) begin
    bit e_run, e_done;
    if (m_valid) begin
      e_run  = (m_q.size() > 0) && !m_q[0];
      e_done = (m_q.size() > 0) && m_q[0];
      chk("En",    int'(En),    int'(e_run));
      chk("Gnt0",  int'(Gnt0),  int'(e_run && !m_owner));
      chk("Gnt1",  int'(Gnt1),  int'(e_run && m_owner));
      chk("Done0", int'(Done0), int'(e_done && !m_owner));
      chk("Done1", int'(Done1), int'(e_done && m_owner));
      chk("Busy",  int'(Busy),  int'(m_q.size() > 0));
      chk("Slt",   int'(Slt),   int'(m_slt));
      chk("Owner", int'(Owner), int'(m_owner));
    end
    if (En && !Slt) en_cnt0++;
    if (En && Slt) en_cnt1++;
    if (Done0) begin done0_cnt++; done0_cyc = cyc; end
    if (Done1) begin done1_cnt++; done1_cyc = cyc; end
    if (En && first_en < 0) first_en = cyc;
    if ((Gnt0 || Gnt1) && !prev_gnt) begin
      gnt_seq.push_back(int'(Gnt1));
      gnt_start.push_back(cyc);
    end
    prev_gnt = Gnt0 || Gnt1;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1; Req0 = 0; Req1 = 0;
    tick();
    Reset = 0;
    tick();
  endtask

  initial begin
    int e;
    int exp_seq[4];
    repeat (3) tick();
    Reset = 0;
    @(negedge Clk);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_owner", int'(Owner), 0);
    chk("reset_en", int'(En), 0);
    tick();

    // Single burst, Len 3 on channel 0.
    do_reset(); clear_trk();
    Req0 = 1; Sel0 = 0; Len0 = 4'd3; e = cyc + 1;
    tick(); Req0 = 0;
    repeat (8) tick();
    chk("s1_first_en", first_en, e);
    chk("s1_en0", en_cnt0, 3);
    chk("s1_en1", en_cnt1, 0);
    chk("s1_done0_cyc", done0_cyc, e + 3);
    chk("s1_done0_cnt", done0_cnt, 1);

    // Requester 1 alone, Len 8 on channel 1.
    do_reset(); clear_trk();
    Req1 = 1; Sel1 = 1; Len1 = 4'd8; e = cyc + 1;
    tick(); Req1 = 0;
    repeat (12) tick();
    chk("s2_first_en", first_en, e);
    chk("s2_en1", en_cnt1, 8);
    chk("s2_en0", en_cnt0, 0);
    chk("s2_done1_cyc", done1_cyc, e + 8);
    chk("s2_done0_cnt", done0_cnt, 0);

    // Both held, Len 2 each.
    do_reset(); clear_trk();
    Req0 = 1; Sel0 = 0; Len0 = 4'd2; Req1 = 1; Sel1 = 1; Len1 = 4'd2; e = cyc + 1;
    repeat (14) tick();
    Req0 = 0; Req1 = 0;
    repeat (6) tick();
`ifdef SCHED_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    chk("s3_grant_count", (gnt_seq.size() >= 4) ? 1 : 0, 1);
    if (gnt_seq.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("s3_grant_owner", gnt_seq[i], exp_seq[i]);
        chk("s3_grant_start", gnt_start[i], e + 4 * i);
      end
    end

    // Zero-length burst.
    do_reset(); clear_trk();
    Req0 = 1; Sel0 = 0; Len0 = 4'd0; e = cyc + 1;
    tick(); Req0 = 0;
    repeat (4) tick();
    chk("s4_done0_cyc", done0_cyc, e);
    chk("s4_en", en_cnt0 + en_cnt1, 0);
    chk("s4_grants", gnt_start.size(), 0);

    // Reset in the 5th RUN cycle of a Len 15 burst.
    do_reset(); clear_trk();
    Req0 = 1; Sel0 = 0; Len0 = 4'd15; e = cyc + 1;
    tick(); Req0 = 0;
    repeat (4) tick();
    Reset = 1;
    tick();
    Reset = 0;
    @(negedge Clk);
    chk("s5_en_after_rst", int'(En), 0);
    chk("s5_busy_after_rst", int'(Busy), 0);
    chk("s5_gnt0_after_rst", int'(Gnt0), 0);
    tick();
    repeat (20) tick();
    chk("s5_en0", en_cnt0, 5);
    chk("s5_done0_cnt", done0_cnt, 0);

    // Req/Sel changed during RUN are ignored.
    do_reset(); clear_trk();
    Req0 = 1; Sel0 = 0; Len0 = 4'd4; e = cyc + 1;
    tick(); tick();
    Req0 = 0; Sel0 = 1; Len0 = 4'd9;
    repeat (8) tick();
    chk("s6_en0", en_cnt0, 4);
    chk("s6_en1", en_cnt1, 0);
    chk("s6_done0_cyc", done0_cyc, e + 4);
    chk("s6_done0_cnt", done0_cnt, 1);

    // Random traffic, occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      Req0  = ($urandom_range(0, 3) != 0);
      Req1  = ($urandom_range(0, 3) != 0);
      Sel0  = 1'($urandom_range(0, 1));
      Sel1  = 1'($urandom_range(0, 1));
      Len0  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      Len1  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      Reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    Reset = 0; Req0 = 0; Req1 = 0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
